// File: rtl/vga_timing_core.sv
// vga_timing_core
//   Parametrised VGA timing generator with a one-pixel pixel pipeline.
//   All state advances only on cycles where pix_en is high.
//
//   Optional feature: define VGA_TESTPAT_EN to add the tp_sel input. While
//   tp_sel is 1, the active area shows 8 vertical colour bars instead of r/g/b.
//
// Ports
//   clk          system clock
//   reset_n      asynchronous active-low reset
//   pix_en       pixel strobe; counters and registered outputs move only when 1
//   tp_sel       (VGA_TESTPAT_EN only) 1 = colour-bar test pattern
//   r, g, b      source pixel for the current (x,y), valid while pix_req = 1
//   x, y         current horizontal / vertical counters
//   pix_req      combinational: (x,y) is inside the active area
//   red/green/blue  registered pixel, zero while blanked
//   H_sync, V_sync  registered syncs, polarity HS_POL / VS_POL
//   vga_blank    registered, 1 = visible pixel (DAC BLANK_n)
//   vga_sync     constant 0 (DAC SYNC_n unused)
//   frame_start  registered one-pix_en pulse for pixel (0,0)
module vga_timing_core #(
  parameter int unsigned CW       = 8,
  parameter int unsigned H_ACTIVE = 640,
  parameter int unsigned H_FP     = 16,
  parameter int unsigned H_SYNC   = 96,
  parameter int unsigned H_BP     = 48,
  parameter int unsigned V_ACTIVE = 480,
  parameter int unsigned V_FP     = 10,
  parameter int unsigned V_SYNC   = 2,
  parameter int unsigned V_BP     = 33,
  parameter logic        HS_POL   = 1'b0,
  parameter logic        VS_POL   = 1'b0,
  localparam int unsigned H_TOTAL = H_ACTIVE + H_FP + H_SYNC + H_BP,
  localparam int unsigned V_TOTAL = V_ACTIVE + V_FP + V_SYNC + V_BP,
  localparam int unsigned XW      = $clog2(H_TOTAL),
  localparam int unsigned YW      = $clog2(V_TOTAL)
) (
  input  logic          clk,
  input  logic          reset_n,
  input  logic          pix_en,
`ifdef VGA_TESTPAT_EN
  input  logic          tp_sel,
`endif
  input  logic [CW-1:0] r,
  input  logic [CW-1:0] g,
  input  logic [CW-1:0] b,
  output logic [XW-1:0] x,
  output logic [YW-1:0] y,
  output logic          pix_req,
  output logic [CW-1:0] red,
  output logic [CW-1:0] green,
  output logic [CW-1:0] blue,
  output logic          H_sync,
  output logic          V_sync,
  output logic          vga_blank,
  output logic          vga_sync,
  output logic          frame_start
);

  localparam int unsigned HS_START = H_ACTIVE + H_FP;
  localparam int unsigned HS_END   = HS_START + H_SYNC;
  localparam int unsigned VS_START = V_ACTIVE + V_FP;
  localparam int unsigned VS_END   = VS_START + V_SYNC;

  logic [XW-1:0] h_cnt;
  logic [YW-1:0] v_cnt;
  logic          h_last;
  logic          v_last;
  logic          hs_raw;
  logic          vs_raw;
  logic          at_origin;
  logic [CW-1:0] src_r;
  logic [CW-1:0] src_g;
  logic [CW-1:0] src_b;

  always_comb begin
    h_last    = (32'(h_cnt) == H_TOTAL - 1);
    v_last    = (32'(v_cnt) == V_TOTAL - 1);
    pix_req   = (32'(h_cnt) < H_ACTIVE) && (32'(v_cnt) < V_ACTIVE);
    hs_raw    = (32'(h_cnt) >= HS_START) && (32'(h_cnt) < HS_END);
    vs_raw    = (32'(v_cnt) >= VS_START) && (32'(v_cnt) < VS_END);
    at_origin = (h_cnt == '0) && (v_cnt == '0);
  end

`ifdef VGA_TESTPAT_EN
  // Bar index only matters inside the active area, where it is 0..7;
  // outside it the value is discarded by the blank gating below.
  logic [2:0] bar_idx;

  always_comb begin
    bar_idx = 3'((32'(h_cnt) * 32'd8) / H_ACTIVE);
    if (tp_sel) begin
      src_r = {CW{bar_idx[2]}};
      src_g = {CW{bar_idx[1]}};
      src_b = {CW{bar_idx[0]}};
    end else begin
      src_r = r;
      src_g = g;
      src_b = b;
    end
  end
`else
  always_comb begin
    src_r = r;
    src_g = g;
    src_b = b;
  end
`endif

  // Counters and output pipeline share one enable so sync, blank and colour
  // always describe the same (pre-edge) pixel.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      h_cnt       <= '0;
      v_cnt       <= '0;
      red         <= '0;
      green       <= '0;
      blue        <= '0;
      vga_blank   <= 1'b0;
      H_sync      <= ~HS_POL;
      V_sync      <= ~VS_POL;
      frame_start <= 1'b0;
    end else if (pix_en) begin
      h_cnt <= h_last ? '0 : h_cnt + 1'b1;
      if (h_last) begin
        v_cnt <= v_last ? '0 : v_cnt + 1'b1;
      end
      red         <= pix_req ? src_r : '0;
      green       <= pix_req ? src_g : '0;
      blue        <= pix_req ? src_b : '0;
      vga_blank   <= pix_req;
      H_sync      <= hs_raw ? HS_POL : ~HS_POL;
      V_sync      <= vs_raw ? VS_POL : ~VS_POL;
      frame_start <= at_origin;
    end
  end

  assign x        = h_cnt;
  assign y        = v_cnt;
  assign vga_sync = 1'b0;

endmodule

// File: tb/tb_vga_timing_core.sv
module tb_vga_timing_core;

  localparam int unsigned HA = 4, HF = 1, HS = 2, HB = 1;
  localparam int unsigned VA = 3, VF = 1, VS = 1, VB = 1;
  localparam int unsigned HT = HA + HF + HS + HB;
  localparam int unsigned VT = VA + VF + VS + VB;
  localparam int unsigned FRAME = HT * VT;
`ifdef VGA_TESTPAT_EN
  localparam logic TB_HS_POL = 1'b1;
`else
  localparam logic TB_HS_POL = 1'b0;
`endif
  localparam logic TB_VS_POL = 1'b0;

  logic       clk = 1'b0;
  logic       reset_n = 1'b0;
  logic       pix_en = 1'b0;
  logic       tp_sel = 1'b0;
  logic [7:0] r = '0, g = '0, b = '0;
  logic [2:0] x;
  logic [2:0] y;
  logic       pix_req;
  logic [7:0] red, green, blue;
  logic       H_sync, V_sync, vga_blank, vga_sync, frame_start;

  vga_timing_core #(
    .CW(8), .H_ACTIVE(HA), .H_FP(HF), .H_SYNC(HS), .H_BP(HB),
    .V_ACTIVE(VA), .V_FP(VF), .V_SYNC(VS), .V_BP(VB),
    .HS_POL(TB_HS_POL), .VS_POL(TB_VS_POL)
  ) dut (
    .clk(clk), .reset_n(reset_n), .pix_en(pix_en),
`ifdef VGA_TESTPAT_EN
    .tp_sel(tp_sel),
`endif
    .r(r), .g(g), .b(b),
    .x(x), .y(y), .pix_req(pix_req),
    .red(red), .green(green), .blue(blue),
    .H_sync(H_sync), .V_sync(V_sync),
    .vga_blank(vga_blank), .vga_sync(vga_sync), .frame_start(frame_start)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic [7:0] red, green, blue;
    logic       blank, hs, vs, fs, req;
    int         x, y;
  } exp_t;

  exp_t q[$];
  int   tests = 0;
  int   fails = 0;
  int   pos   = 0;   // frame-linear pixel index the DUT currently sits on

  task automatic cmp(input string name, input int act, input int exp);
    tests++;
    if (act != exp) begin
      fails++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  function automatic exp_t reset_exp();
    exp_t e;
    e.red = '0; e.green = '0; e.blue = '0;
    e.blank = 1'b0; e.hs = ~TB_HS_POL; e.vs = ~TB_VS_POL; e.fs = 1'b0;
    e.x = 0; e.y = 0; e.req = 1'b1;
    return e;
  endfunction

  // Reference: outputs after a pix_en edge taken at pixel p with inputs rr/gg/bb.
  function automatic exp_t model(input int p, input logic [7:0] rr, gg, bb, input logic tp);
    exp_t e;
    int   px, py, np, idx;
    logic act;
    logic [7:0] cr, cg, cb;
    px  = p % HT;
    py  = p / HT;
    act = (px < HA) && (py < VA);
    cr = rr; cg = gg; cb = bb;
    if (tp) begin
      idx = (px * 8) / HA;
      cr = (idx & 4) != 0 ? 8'hFF : 8'h00;
      cg = (idx & 2) != 0 ? 8'hFF : 8'h00;
      cb = (idx & 1) != 0 ? 8'hFF : 8'h00;
    end
    e.red   = act ? cr : 8'h00;
    e.green = act ? cg : 8'h00;
    e.blue  = act ? cb : 8'h00;
    e.blank = act;
    e.hs = (px >= HA + HF && px < HA + HF + HS) ? TB_HS_POL : ~TB_HS_POL;
    e.vs = (py >= VA + VF && py < VA + VF + VS) ? TB_VS_POL : ~TB_VS_POL;
    e.fs = (p == 0);
    np  = (p + 1) % FRAME;
    e.x = np % HT;
    e.y = np / HT;
    e.req = (e.x < HA) && (e.y < VA);
    return e;
  endfunction

  task automatic check_all(input string tag, input exp_t e);
    cmp({tag, "_red"},   int'(red),   int'(e.red));
    cmp({tag, "_green"}, int'(green), int'(e.green));
    cmp({tag, "_blue"},  int'(blue),  int'(e.blue));
    cmp({tag, "_blank"}, int'(vga_blank), int'(e.blank));
    cmp({tag, "_hsync"}, int'(H_sync), int'(e.hs));
    cmp({tag, "_vsync"}, int'(V_sync), int'(e.vs));
    cmp({tag, "_fstart"}, int'(frame_start), int'(e.fs));
    cmp({tag, "_x"}, int'(x), e.x);
    cmp({tag, "_y"}, int'(y), e.y);
    cmp({tag, "_pixreq"}, int'(pix_req), int'(e.req));
    cmp({tag, "_vgasync"}, int'(vga_sync), 0);
  endtask

  // Monitor: pops an expectation per accepted pix_en edge; on stalled edges
  // the outputs must still equal the last expectation.
  exp_t last;
  initial last = reset_exp();

  always @(posedge clk) begin
    if (!reset_n) begin
      last = reset_exp();
    end else if (pix_en) begin
      #1;
      if (q.size() == 0) begin
        cmp("queue_underflow", 1, 0);
      end else begin
        last = q.pop_front();
        check_all("pix", last);
      end
    end else begin
      #1;
      check_all("hold", last);
    end
  end

  // One clock of stimulus, driven at the falling edge.
  task automatic step(input logic en);
    @(negedge clk);
    pix_en = en;
    if (en && reset_n) begin
      r = 8'($urandom);
      g = 8'($urandom);
      b = 8'($urandom);
`ifdef VGA_TESTPAT_EN
      tp_sel = 1'($urandom);
`endif
      q.push_back(model(pos, r, g, b, tp_sel));
      pos = (pos + 1) % FRAME;
    end
  endtask

  task automatic run_pix(input int n);
    for (int i = 0; i < n; i++) begin
      step(1'b1);
      step(1'b0);
    end
  endtask

  initial begin
    // Reset held across three pix_en strobes.
    for (int i = 0; i < 3; i++) begin
      step(1'b1);
      step(1'b0);
    end
    check_all("reset", reset_exp());
    @(negedge clk);
    reset_n = 1'b1;
    pos = 0;

    // Two frames and a bit: colour, blanking, syncs, wraps, frame_start.
    run_pix(2 * FRAME + 3);

    // Mid-line stall.
    for (int i = 0; i < 5; i++) step(1'b0);
    run_pix(20);

    // Advance to (2,1), then reset asynchronously between clock edges.
    for (int i = 0; i < FRAME && pos != (1 * HT + 2); i++) run_pix(1);
    cmp("reach_2_1", pos, 1 * HT + 2);
    @(negedge clk);
    #2 reset_n = 1'b0;
    #1 check_all("async_reset", reset_exp());
    cmp("queue_empty_at_reset", q.size(), 0);
    q.delete();
    for (int i = 0; i < 4; i++) step(1'b0);
    @(negedge clk);
    reset_n = 1'b1;
    pos = 0;
    run_pix(FRAME + 5);

    step(1'b0);
    step(1'b0);
    cmp("queue_drained", q.size(), 0);
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL timeout: simulation exceeded time bound");
    $fatal(1, "timeout");
  end

endmodule
